// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

    localparam int DW_DEFAULT = 16;
    localparam int CNT_W      = $clog2(2 * DW_DEFAULT);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    function automatic int cnt_w(input int dw);
        return $clog2(2 * dw);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step
    import div_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic [DW-1:0] rem_i,
    input  logic          bit_i,
    input  logic [DW-1:0] d_i,
    output logic [DW-1:0] rem_o,
    output logic          q_bit_o
);

    logic [DW:0] shifted;
    logic [DW:0] trial;

    // rem_i < d_i on entry, so the true difference lies in [-d, d-1] and the
    // MSB of the DW+1-bit trial is a reliable sign bit.
    always_comb begin
        shifted = {rem_i, bit_i};
        trial   = shifted - {1'b0, d_i};
        q_bit_o = ~trial[DW];
        rem_o   = q_bit_o ? trial[DW-1:0] : shifted[DW-1:0];
    end

endmodule

// File: rtl/seq_divider_32x16.sv
// Multi-cycle restoring divider (2*DW / DW), one quotient bit per clock, valid/ready on both sides.
// Define DIV_SELF_CHECK_EN to add a q*d+r == n result checker driving chk_err.
module seq_divider_32x16
    import div_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*DW-1:0] n,
    input  logic [DW-1:0]   d,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*DW-1:0] q,
    output logic [DW-1:0]   r,
    output logic            dz,
    output logic            chk_err
);

    localparam int CW = cnt_w(DW);

    state_t          state_q, state_d;
    logic [2*DW-1:0] sreg_q, sreg_d;
    logic [DW-1:0]   rem_q, rem_d;
    logic [DW-1:0]   d_q, d_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [2*DW-1:0] q_q, q_d;
    logic [DW-1:0]   r_q, r_d;
    logic            dz_q, dz_d;

    logic [DW-1:0]   step_rem;
    logic            step_bit;

    div_step #(.DW(DW)) u_step (
        .rem_i   (rem_q),
        .bit_i   (sreg_q[2*DW-1]),
        .d_i     (d_q),
        .rem_o   (step_rem),
        .q_bit_o (step_bit)
    );

    always_comb begin
        // NOTE: every *_d is given its hold value before the case, so no branch leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        sreg_d      = sreg_q;
        rem_d       = rem_q;
        d_d         = d_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        q_d         = q_q;
        r_d         = r_q;
        dz_d        = dz_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    d_d        = d;
                    in_ready_d = 1'b0;
                    if (d == '0) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        q_d         = '1;
                        r_d         = n[DW-1:0];
                        dz_d        = 1'b1;
                    end else begin
                        state_d = CALC;
                        rem_d   = '0;
                        sreg_d  = n;
                        cnt_d   = CW'(2*DW - 1);
                    end
                end
            end
            CALC: begin
                // Dividend bits leave at the MSB while quotient bits enter at the LSB.
                rem_d  = step_rem;
                sreg_d = {sreg_q[2*DW-2:0], step_bit};
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    q_d         = {sreg_q[2*DW-2:0], step_bit};
                    r_d         = step_rem;
                    dz_d        = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

`ifdef DIV_SELF_CHECK_EN
    logic [2*DW-1:0] n_q, n_d;
    logic            chk_err_q, chk_err_d;
    logic [3*DW-1:0] recon;

    // Evaluated on the values DONE will present, so the flag is valid from the first DONE cycle.
    always_comb begin
        n_d = n_q;
        if (state_q == IDLE && in_valid) begin
            n_d = n;
        end
        recon     = (3*DW)'(q_d) * (3*DW)'(d_q) + (3*DW)'(r_d);
        chk_err_d = (state_d == DONE) && !dz_d &&
                    ((recon != (3*DW)'(n_q)) || (r_d >= d_q));
    end

    assign chk_err = chk_err_q;
`else
    assign chk_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q     <= IDLE;
            sreg_q      <= '0;
            rem_q       <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            q_q         <= '0;
            r_q         <= '0;
            dz_q        <= 1'b0;
`ifdef DIV_SELF_CHECK_EN
            n_q         <= '0;
            chk_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            rem_q       <= rem_d;
            d_q         <= d_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            q_q         <= q_d;
            r_q         <= r_d;
            dz_q        <= dz_d;
`ifdef DIV_SELF_CHECK_EN
            n_q         <= n_d;
            chk_err_q   <= chk_err_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign q         = q_q;
    assign r         = r_q;
    assign dz        = dz_q;

endmodule

// File: tb/tb_seq_divider_32x16.sv
// Scoreboard bench for seq_divider_32x16: directed cases plus randomized operands against an arithmetic model.
module tb_seq_divider_32x16;
    import div_pkg::*;

    localparam int DW = 16;

    typedef struct packed {
        logic [2*DW-1:0] q;
        logic [DW-1:0]   r;
        logic            dz;
    } res_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [2*DW-1:0] n;
    logic [DW-1:0]   d;
    logic            out_valid;
    logic            out_ready;
    logic [2*DW-1:0] q;
    logic [DW-1:0]   r;
    logic            dz;
    logic            chk_err;

    int   n_checks = 0;
    int   n_fail   = 0;
    res_t exp_q[$];

    always #5 clk = ~clk;

    seq_divider_32x16 #(.DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .n         (n),
        .d         (d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .r         (r),
        .dz        (dz),
        .chk_err   (chk_err)
    );

    function automatic res_t model(input logic [2*DW-1:0] nn, input logic [DW-1:0] dd);
        res_t res;
        if (dd == '0) begin
            res.q  = '1;
            res.r  = nn[DW-1:0];
            res.dz = 1'b1;
        end else begin
            res.q  = nn / {{DW{1'b0}}, dd};
            res.r  = DW'(nn % {{DW{1'b0}}, dd});
            res.dz = 1'b0;
        end
        return res;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // Monitor: pops one expectation per completed output handshake.
    always @(negedge clk) begin : monitor
        res_t e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                fail_event("spurious_result");
            end else begin
                e = exp_q.pop_front();
                check("mon_q", 64'(q), 64'(e.q));
                check("mon_r", 64'(r), 64'(e.r));
                check("mon_dz", 64'(dz), 64'(e.dz));
                check("mon_chk_err", 64'(chk_err), 64'(0));
            end
        end
    end

    task automatic issue(input logic [2*DW-1:0] nn, input logic [DW-1:0] dd);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        n        = nn;
        d        = dd;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            fail_event("issue_timeout");
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            exp_q.push_back(model(nn, dd));
            #1;
            in_valid = 1'b0;
        end
    endtask

    // lat = index of the first cycle after acceptance with out_valid high, -1 on timeout.
    task automatic wait_out(input int budget, output int lat);
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_directed(input string tag, input logic [2*DW-1:0] nn, input logic [DW-1:0] dd,
                                input int exp_lat, input logic [2*DW-1:0] eq,
                                input logic [DW-1:0] er, input logic edz);
        int lat;
        out_ready = 1'b0;
        issue(nn, dd);
        wait_out(3*DW, lat);
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_q"}, 64'(q), 64'(eq));
        check({tag, "_r"}, 64'(r), 64'(er));
        check({tag, "_dz"}, 64'(dz), 64'(edz));
        check({tag, "_chk_err"}, 64'(chk_err), 64'(0));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin : driver
        int  lat;
        bit  rand_done;
        logic [2*DW-1:0] rn;
        logic [DW-1:0]   rd;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n         = '0;
        d         = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", 64'(in_ready), 64'(1));
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_q", 64'(q), 64'(0));
        check("reset_r", 64'(r), 64'(0));
        check("reset_dz", 64'(dz), 64'(0));
        check("reset_chk_err", 64'(chk_err), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_directed("div_225_15", 32'h0000_00E1, 16'h000F, 33, 32'h0000_000F, 16'h0000, 1'b0);
        run_directed("div_max_max", 32'hFFFF_FFFF, 16'hFFFF, 33, 32'h0001_0001, 16'h0000, 1'b0);
        run_directed("div_100_7", 32'd100, 16'd7, 33, 32'd14, 16'd2, 1'b0);
        run_directed("div_by_zero", 32'd1234, 16'd0, 1, 32'hFFFF_FFFF, 16'h04D2, 1'b1);

        // Back-pressure, in_valid ignored outside IDLE, no chaining of out_ready and in_valid.
        out_ready = 1'b0;
        issue(32'd100, 16'd7);
        in_valid = 1'b1;
        n        = 32'd5000;
        d        = 16'd3;
        repeat (5) @(negedge clk);
        check("calc_in_ready_low", 64'(in_ready), 64'(0));
        check("calc_out_valid_low", 64'(out_valid), 64'(0));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_out(3*DW, lat);
        check("bp_latency", 64'(lat), 64'(28));
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_out_valid", 64'(out_valid), 64'(1));
            check("hold_q", 64'(q), 64'(14));
            check("hold_r", 64'(r), 64'(2));
            check("hold_dz", 64'(dz), 64'(0));
            check("hold_in_ready", 64'(in_ready), 64'(0));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_in_ready", 64'(in_ready), 64'(1));
        check("release_out_valid", 64'(out_valid), 64'(0));
        issue(32'd5000, 16'd3);
        wait_out(3*DW, lat);
        check("queued_latency", 64'(lat), 64'(33));
        @(posedge clk);
        #1;

        // Reset in the middle of CALC abandons the operation.
        issue(32'd100, 16'd7);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        check("midcalc_rst_in_ready", 64'(in_ready), 64'(1));
        check("midcalc_rst_out_valid", 64'(out_valid), 64'(0));
        run_directed("after_rst_100_7", 32'd100, 16'd7, 33, 32'd14, 16'd2, 1'b0);

        // Randomized operands with random back-pressure.
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    case ($urandom_range(0, 9))
                        0:       rd = '0;
                        1, 2, 3: rd = DW'($urandom_range(1, 255));
                        4:       rd = '1;
                        default: rd = DW'($urandom);
                    endcase
                    rn = ($urandom_range(0, 4) == 0) ? (2*DW)'($urandom_range(0, 70000)) : (2*DW)'($urandom);
                    issue(rn, rd);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            @(posedge clk);
        end
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        @(posedge clk);
        #1;

`ifdef DIV_SELF_CHECK_EN
        out_ready = 1'b0;
        issue(32'd100, 16'd7);
        wait_out(3*DW, lat);
        check("selfchk_clean", 64'(chk_err), 64'(0));
        @(posedge clk);
        #1;
        force dut.r_q = 16'd9;
        @(posedge clk);
        #1;
        check("selfchk_corrupt_r", 64'(chk_err), 64'(1));
        release dut.r_q;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        check("selfchk_cleared_by_rst", 64'(chk_err), 64'(0));
        out_ready = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
